// File: rtl/floor_request_scheduler_pkg.sv
// Shared definitions for the elevator floor request scheduler.
// Contents: default floor count and code width, scheduler state encoding,
// sweep direction constants, floor-code to bit-index helper.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS = 7;
  localparam int unsigned DEF_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2,
    SERVE  = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Floors are numbered from 1; bit 0 of a floor mask is floor 1.
  function automatic int floor_to_idx(input int floor);
    return floor - 1;
  endfunction

endpackage

// File: rtl/floor_request_scheduler_btn_debounce.sv
// btn_debounce: one call button input path.
// A 2-flop synchroniser feeds a stability counter; the debounced level only
// changes after DEBOUNCE_CYCLES consecutive samples differ from it.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_btn    : raw asynchronous button
//   o_rise   : one-cycle pulse, registered, on the debounced rising edge
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;

  // Synchroniser, stability counter and edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th differing sample in a row.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: turns per-floor call buttons into one target floor
// using a SCAN policy (keep direction, then reverse), offered over valid/ready.
// Optional macro ELEV_RETARGET_EN: while serving, a new call strictly between
// the car and its target (in the sweep direction) re-runs the selection so the
// nearer floor is offered first; the old target stays pending.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   call_btn      : raw buttons, bit i = floor i+1
//   cur_floor     : current car floor (1..NUM_FLOORS)
//   arrived       : one-cycle pulse, car stopped at cur_floor
//   target_floor  : selected destination (registered)
//   target_valid  : target_floor offered (registered)
//   target_ready  : consumer accepts the target
//   dir_up        : current sweep direction, 1 = up (registered)
//   pending       : latched outstanding calls, also drives LEDs (registered)
//   busy          : high in every state except IDLE (registered)
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS      = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W         = DEF_FLOOR_W,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  input  logic                  target_ready,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  state_t                  r_state;
  logic [FLOOR_W-1:0]      r_target;
  logic                    r_valid;
  logic                    r_dir_up;
  logic [NUM_FLOORS-1:0]   r_pending;
  logic                    r_busy;

  state_t                  w_state_nxt;
  logic [FLOOR_W-1:0]      w_target_nxt;
  logic                    w_dir_nxt;
  logic [NUM_FLOORS-1:0]   w_rise;
  logic [NUM_FLOORS-1:0]   w_cur_mask;
  logic [NUM_FLOORS-1:0]   w_set;
  logic [NUM_FLOORS-1:0]   w_clr;
  logic [NUM_FLOORS-1:0]   w_pending_nxt;
  logic                    w_up_found;
  logic [FLOOR_W-1:0]      w_up_floor;
  logic                    w_dn_found;
  logic [FLOOR_W-1:0]      w_dn_floor;
  logic                    w_fwd_found;
  logic [FLOOR_W-1:0]      w_fwd_floor;
  logic                    w_rev_found;
  logic [FLOOR_W-1:0]      w_rev_floor;
  logic                    w_cur_pend;
  logic                    w_retarget;

  // One debouncer per floor button.
  for (genvar g = 0; g < int'(NUM_FLOORS); g++) begin : gen_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .i_btn (call_btn[g]),
      .o_rise(w_rise[g])
    );
  end

  // One-hot of cur_floor; all zero for code 0 or codes above NUM_FLOORS,
  // which makes out-of-range arrivals clear nothing.
  always_comb begin
    w_cur_mask = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      w_cur_mask[i] = (cur_floor != '0) && (floor_to_idx(int'(cur_floor)) == i);
    end
  end

  // Pending update: presses at the car's floor are dropped while idle; a clear
  // beats a set on the same bit.
  always_comb begin
    w_set         = w_rise & ~((r_state == IDLE) ? w_cur_mask : '0);
    w_clr         = arrived ? w_cur_mask : '0;
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = '0;
    w_dn_found = 1'b0;
    w_dn_floor = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (r_pending[i] && (i + 1 > int'(cur_floor))) begin
        w_up_found = 1'b1;
        w_up_floor = FLOOR_W'(i + 1);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (r_pending[i] && (i + 1 < int'(cur_floor))) begin
        w_dn_found = 1'b1;
        w_dn_floor = FLOOR_W'(i + 1);
      end
    end
    w_cur_pend  = |(r_pending & w_cur_mask);
    w_fwd_found = (r_dir_up == DIR_UP) ? w_up_found : w_dn_found;
    w_fwd_floor = (r_dir_up == DIR_UP) ? w_up_floor : w_dn_floor;
    w_rev_found = (r_dir_up == DIR_UP) ? w_dn_found : w_up_found;
    w_rev_floor = (r_dir_up == DIR_UP) ? w_dn_floor : w_up_floor;
  end

`ifdef ELEV_RETARGET_EN
  logic [NUM_FLOORS-1:0] w_between;

  // Floors strictly between the car and the current target, sweep direction.
  always_comb begin
    w_between = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (r_dir_up == DIR_UP) begin
        w_between[i] = (i + 1 > int'(cur_floor)) && (i + 1 < int'(r_target));
      end else begin
        w_between[i] = (i + 1 < int'(cur_floor)) && (i + 1 > int'(r_target));
      end
    end
  end

  assign w_retarget = |(w_set & ~w_clr & w_between);
`else
  assign w_retarget = 1'b0;
`endif

  // Next-state, target and direction.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dir_nxt    = r_dir_up;
    case (r_state)
      IDLE: begin
        if (|r_pending) w_state_nxt = SELECT;
      end
      SELECT: begin
        if (w_fwd_found) begin
          w_target_nxt = w_fwd_floor;
          w_state_nxt  = OFFER;
        end else if (w_rev_found) begin
          w_target_nxt = w_rev_floor;
          w_dir_nxt    = ~r_dir_up;
          w_state_nxt  = OFFER;
        end else if (w_cur_pend) begin
          // Call at the car's own floor: finish it in SERVE without an offer.
          w_target_nxt = cur_floor;
          w_state_nxt  = SERVE;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      OFFER: begin
        if (target_ready) w_state_nxt = SERVE;
      end
      SERVE: begin
        if (arrived && (cur_floor == r_target)) begin
          w_state_nxt = SELECT;
        end else if (w_retarget) begin
          w_state_nxt = SELECT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; valid/busy are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_target  <= FLOOR_W'(1);
      r_valid   <= 1'b0;
      r_dir_up  <= DIR_UP;
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_valid   <= (w_state_nxt == OFFER);
      r_dir_up  <= w_dir_nxt;
      r_pending <= w_pending_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign target_floor = r_target;
  assign target_valid = r_valid;
  assign dir_up       = r_dir_up;
  assign pending      = r_pending;
  assign busy         = r_busy;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Self-checking bench for floor_request_scheduler (DEBOUNCE_CYCLES = 4).
// Honours ELEV_RETARGET_EN for the retarget sequence.
module tb_floor_request_scheduler;

  logic       clk;
  logic       rst;
  logic [6:0] call_btn;
  logic [2:0] cur_floor;
  logic       arrived;
  logic [2:0] target_floor;
  logic       target_valid;
  logic       target_ready;
  logic       dir_up;
  logic [6:0] pending;
  logic       busy;

  int total;
  int bad;

  floor_request_scheduler #(
    .NUM_FLOORS     (7),
    .FLOOR_W        (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_btn    (call_btn),
    .cur_floor   (cur_floor),
    .arrived     (arrived),
    .target_floor(target_floor),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .dir_up      (dir_up),
    .pending     (pending),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SCAN scenario: start floor, buttons pressed together, offers in order.
  typedef struct packed {
    logic [2:0]      cur;
    logic [6:0]      mask;
    logic [2:0]      n;
    logic [5:0][2:0] tgt;
    logic [5:0]      dir;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [2:0] c, input logic [6:0] m,
                              input logic [2:0] n, input logic [17:0] t,
                              input logic [5:0] d);
    vec_t v;
    v.cur  = c;
    v.mask = m;
    v.n    = n;
    v.tgt  = t;
    v.dir  = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    int n;
    n = 0;
    while (!target_valid && n < 50) begin
      tick();
      n++;
    end
    ok = target_valid;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got no target_valid within %0d cycles want valid", nm, n);
    end
  endtask

  task automatic do_reset();
    call_btn     = '0;
    arrived      = 1'b0;
    target_ready = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press(input logic [6:0] m);
    call_btn = m;
    repeat (6) tick();
    call_btn = '0;
  endtask

  task automatic accept(input string nm);
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    chk(nm, int'(target_valid), 0);
  endtask

  task automatic arrive(input logic [2:0] f);
    cur_floor = f;
    arrived   = 1'b1;
    tick();
    arrived   = 1'b0;
  endtask

  initial begin
    bit         ok;
    vec_t       v;
    logic [6:0] exp_p;

    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    call_btn     = '0;
    cur_floor    = 3'd1;
    arrived      = 1'b0;
    target_ready = 1'b0;

    vecs[0] = mk(3'd1, 7'b0010000, 3'd1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}, 6'b000001);
    vecs[1] = mk(3'd4, 7'b1100010, 3'd3, {3'd0, 3'd0, 3'd0, 3'd2, 3'd7, 3'd6}, 6'b000011);
    vecs[2] = mk(3'd7, 7'b0000101, 3'd2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3}, 6'b000000);
    vecs[3] = mk(3'd3, 7'b0010010, 3'd2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd5}, 6'b000001);
    vecs[4] = mk(3'd4, 7'b0101000, 3'd1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6}, 6'b000001);
    vecs[5] = mk(3'd1, 7'b1111110, 3'd6, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2}, 6'b111111);
    vecs[6] = mk(3'd7, 7'b0000001, 3'd1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 6'b000000);
    vecs[7] = mk(3'd5, 7'b1000001, 3'd2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd7}, 6'b000001);

    // Reset values while reset is held.
    #2;
    chk("rst_target", int'(target_floor), 1);
    chk("rst_valid", int'(target_valid), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);

    // Single call: exact latency, stable target while ready is low, completion.
    do_reset();
    cur_floor = 3'd1;
    call_btn  = 7'b0010000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 6) begin
        chk("lat_pend_before", int'(pending), 0);
        call_btn = '0;
      end
      if (c == 7) chk("lat_pend_set", int'(pending), 16);
      if (c == 8) chk("lat_valid_early", int'(target_valid), 0);
    end
    chk("lat_valid", int'(target_valid), 1);
    chk("lat_target", int'(target_floor), 5);
    chk("lat_dir", int'(dir_up), 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_target", int'(target_floor), 5);
      chk("hold_valid", int'(target_valid), 1);
    end
    accept("single_accept");
    tick();
    arrive(3'd5);
    chk("single_pending", int'(pending), 0);
    tick();
    tick();
    chk("single_busy", int'(busy), 0);

    // Table of SCAN scenarios.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      do_reset();
      cur_floor = v.cur;
      press(v.mask);
      exp_p = v.mask & ~(7'(1) << (int'(v.cur) - 1));
      for (int k = 0; k < int'(v.n); k++) begin
        wait_valid($sformatf("v%0d_wait%0d", i, k), ok);
        if (!ok) break;
        if (k == 0) chk($sformatf("v%0d_pending", i), int'(pending), int'(exp_p));
        chk($sformatf("v%0d_tgt%0d", i, k), int'(target_floor), int'(v.tgt[3'(k)]));
        chk($sformatf("v%0d_dir%0d", i, k), int'(dir_up), int'(v.dir[3'(k)]));
        accept($sformatf("v%0d_acc%0d", i, k));
        tick();
        arrive(v.tgt[3'(k)]);
      end
      repeat (4) tick();
      chk($sformatf("v%0d_end_pending", i), int'(pending), 0);
      chk($sformatf("v%0d_end_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_end_valid", i), int'(target_valid), 0);
    end

    // Bounce shorter than the debounce window, then a clean hold.
    do_reset();
    cur_floor = 3'd1;
    call_btn  = 7'b0000100;
    repeat (2) tick();
    call_btn = '0;
    repeat (2) tick();
    call_btn = 7'b0000100;
    repeat (2) tick();
    call_btn = '0;
    repeat (12) tick();
    chk("bounce_pending", int'(pending), 0);
    chk("bounce_valid", int'(target_valid), 0);
    call_btn = 7'b0000100;
    repeat (12) tick();
    call_btn = '0;
    chk("hold_pending", int'(pending), 4);
    wait_valid("hold_wait", ok);
    chk("hold_tgt3", int'(target_floor), 3);
    accept("hold_accept");
    arrive(3'd3);
    repeat (3) tick();
    chk("hold_end_pending", int'(pending), 0);

    // Set and clear of the same bit in the same cycle: clear wins.
    do_reset();
    cur_floor = 3'd1;
    press(7'b0100000);
    wait_valid("coll_wait", ok);
    accept("coll_accept");
    cur_floor = 3'd3;
    call_btn  = 7'b0000100;
    repeat (6) tick();
    arrived = 1'b1;
    tick();
    arrived  = 1'b0;
    call_btn = '0;
    repeat (2) tick();
    chk("coll_pending", int'(pending), 32);
    arrive(3'd6);
    repeat (3) tick();
    chk("coll_end_pending", int'(pending), 0);
    chk("coll_end_busy", int'(busy), 0);

    // Press at the car's floor while idle is dropped.
    do_reset();
    cur_floor = 3'd4;
    press(7'b0001000);
    repeat (10) tick();
    chk("here_pending", int'(pending), 0);
    chk("here_valid", int'(target_valid), 0);
    chk("here_busy", int'(busy), 0);

    // Asynchronous reset during OFFER.
    do_reset();
    cur_floor = 3'd1;
    press(7'b0000010);
    wait_valid("arst_wait", ok);
    chk("arst_pre_target", int'(target_floor), 2);
    rst = 1'b1;
    #1;
    chk("arst_target", int'(target_floor), 1);
    chk("arst_valid", int'(target_valid), 0);
    chk("arst_dir", int'(dir_up), 1);
    chk("arst_pending", int'(pending), 0);
    chk("arst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // New call between car and target while serving.
    do_reset();
    cur_floor = 3'd1;
    press(7'b0100000);
    wait_valid("rt_wait0", ok);
    chk("rt_tgt0", int'(target_floor), 6);
    accept("rt_acc0");
    press(7'b0000100);
`ifdef ELEV_RETARGET_EN
    wait_valid("rt_wait1", ok);
    chk("rt_tgt1", int'(target_floor), 3);
    chk("rt_dir1", int'(dir_up), 1);
    chk("rt_pend1", int'(pending), 36);
    accept("rt_acc1");
    arrive(3'd3);
    wait_valid("rt_wait2", ok);
    chk("rt_tgt2", int'(target_floor), 6);
    chk("rt_dir2", int'(dir_up), 1);
    accept("rt_acc2");
    arrive(3'd6);
`else
    repeat (8) tick();
    chk("rt_no_offer", int'(target_valid), 0);
    chk("rt_pend1", int'(pending), 36);
    arrive(3'd6);
    wait_valid("rt_wait1", ok);
    chk("rt_tgt1", int'(target_floor), 3);
    chk("rt_dir1", int'(dir_up), 0);
    accept("rt_acc1");
    arrive(3'd3);
`endif
    repeat (3) tick();
    chk("rt_end_pending", int'(pending), 0);
    chk("rt_end_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
